// File: rtl/pc_sequencer.sv
// IF-stage program counter: next-PC selection, IF/ID flush and a boot/run(/trap) fetch gate.
// Define PC_ALIGN_CHECK_EN to trap on misaligned redirect targets instead of masking them.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned BOOT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_add4_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  output logic [31:0] pc_o,
  output logic        fetch_valid_o,
  output logic        flush_o,
  output logic [31:0] fetch_count_o,
  output logic [15:0] stall_count_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {StBoot, StRun, StTrap} state_e;

  // BOOT_CYCLES of 0 and 1 both leave BOOT on the first edge after reset.
  localparam logic [3:0] BootLast = (BOOT_CYCLES == 0) ? 4'd0 : 4'(BOOT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  boot_cnt_q, boot_cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        redirect;
  logic [31:0] target;
  logic        flush;
`ifdef PC_ALIGN_CHECK_EN
  logic        misalign_q, misalign_d;
`endif

  assign redirect = jump_i | branch_taken_i;
  assign target   = jump_i ? jump_target_i : branch_target_i;

  always_comb begin
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    pc_d        = pc_q;
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush       = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    misalign_d  = misalign_q;
`endif
    unique case (state_q)
      StBoot: begin
        if (boot_cnt_q == BootLast) begin
          state_d = StRun;
        end else begin
          boot_cnt_d = boot_cnt_q + 4'd1;
        end
      end
      StRun: begin
        if (redirect) begin
          flush = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
          if (target[1:0] != 2'b00) begin
            state_d    = StTrap;
            misalign_d = 1'b1;
          end else begin
            pc_d        = target;
            fetch_cnt_d = fetch_cnt_q + 32'd1;
          end
`else
          pc_d        = target & 32'hFFFF_FFFC;
          fetch_cnt_d = fetch_cnt_q + 32'd1;
`endif
        end else if (stall_i) begin
          if (stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
          end
        end else begin
          pc_d        = pc_add4_i;
          fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
      end
      StTrap: begin
        // Only reset leaves TRAP; everything stays frozen.
        state_d = StTrap;
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StBoot;
      boot_cnt_q  <= 4'd0;
      pc_q        <= RESET_PC;
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 16'd0;
`ifdef PC_ALIGN_CHECK_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      pc_q        <= pc_d;
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
`ifdef PC_ALIGN_CHECK_EN
      misalign_q  <= misalign_d;
`endif
    end
  end

  assign pc_o          = pc_q;
  assign fetch_valid_o = (state_q == StRun);
  assign flush_o       = flush & ~reset;
  assign fetch_count_o = fetch_cnt_q;
  assign stall_count_o = stall_cnt_q;
`ifdef PC_ALIGN_CHECK_EN
  assign misalign_o    = misalign_q;
`else
  assign misalign_o    = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (RESET_PC=0, BOOT_CYCLES=2).
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_add4_i;
  logic        stall_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        jump_i;
  logic [31:0] jump_target_i;
  logic [31:0] pc_o;
  logic        fetch_valid_o;
  logic        flush_o;
  logic [31:0] fetch_count_o;
  logic [15:0] stall_count_o;
  logic        misalign_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Stand-in for the external PC+4 adder.
  assign pc_add4_i = pc_o + 32'd4;

  pc_sequencer #(
    .RESET_PC   (32'h0000_0000),
    .BOOT_CYCLES(2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pc_add4_i      (pc_add4_i),
    .stall_i        (stall_i),
    .branch_taken_i (branch_taken_i),
    .branch_target_i(branch_target_i),
    .jump_i         (jump_i),
    .jump_target_i  (jump_target_i),
    .pc_o           (pc_o),
    .fetch_valid_o  (fetch_valid_o),
    .flush_o        (flush_o),
    .fetch_count_o  (fetch_count_o),
    .stall_count_o  (stall_count_o),
    .misalign_o     (misalign_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall_i         = 1'b0;
    branch_taken_i  = 1'b0;
    branch_target_i = 32'd0;
    jump_i          = 1'b0;
    jump_target_i   = 32'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    step();
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (pc_o !== 32'h0) begin
      failures++; $display("FAIL reset_pc got %h exp %h", pc_o, 32'h0);
    end
    checks++;
    if (fetch_valid_o !== 1'b0 || flush_o !== 1'b0 || misalign_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got fv=%b fl=%b mis=%b exp 0 0 0",
               fetch_valid_o, flush_o, misalign_o);
    end
    checks++;
    if (fetch_count_o !== 32'd0 || stall_count_o !== 16'd0) begin
      failures++;
      $display("FAIL reset_counts got fc=%0d sc=%0d exp 0 0", fetch_count_o, stall_count_o);
    end
  endtask

  task automatic test_boot_run();
    step();
    checks++;
    if (fetch_valid_o !== 1'b0) begin
      failures++; $display("FAIL boot_fv1 got %b exp 0", fetch_valid_o);
    end
    step();
    checks++;
    if (fetch_valid_o !== 1'b1 || pc_o !== 32'h0) begin
      failures++; $display("FAIL boot_run got fv=%b pc=%h exp 1 00000000", fetch_valid_o, pc_o);
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (pc_o !== 32'(4 * i)) begin
        failures++; $display("FAIL run_pc%0d got %h exp %h", i, pc_o, 32'(4 * i));
      end
    end
    checks++;
    if (fetch_count_o !== 32'd3) begin
      failures++; $display("FAIL run_fcount got %0d exp 3", fetch_count_o);
    end
  endtask

  task automatic test_stall();
    step(); // pc 0x10
    stall_i = 1'b1;
    #1;
    checks++;
    if (flush_o !== 1'b0) begin
      failures++; $display("FAIL stall_flush got %b exp 0", flush_o);
    end
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (pc_o !== 32'h10 || stall_count_o !== 16'd3 || fetch_count_o !== 32'd4) begin
      failures++;
      $display("FAIL stall_hold got pc=%h sc=%0d fc=%0d exp 10 3 4",
               pc_o, stall_count_o, fetch_count_o);
    end
    stall_i = 1'b0;
    step();
    checks++;
    if (pc_o !== 32'h14 || fetch_count_o !== 32'd5) begin
      failures++; $display("FAIL stall_release got pc=%h fc=%0d exp 14 5", pc_o, fetch_count_o);
    end
  endtask

  task automatic test_branch_jump();
    step(); step(); step(); // pc 0x20, fc 8
    branch_taken_i  = 1'b1;
    branch_target_i = 32'h100;
    #1;
    checks++;
    if (flush_o !== 1'b1) begin
      failures++; $display("FAIL branch_flush got %b exp 1", flush_o);
    end
    step();
    checks++;
    if (pc_o !== 32'h100 || fetch_count_o !== 32'd9) begin
      failures++; $display("FAIL branch_pc got pc=%h fc=%0d exp 100 9", pc_o, fetch_count_o);
    end
    jump_i          = 1'b1;
    jump_target_i   = 32'h200;
    branch_target_i = 32'h300;
    step();
    checks++;
    if (pc_o !== 32'h200) begin
      failures++; $display("FAIL jump_prio got %h exp 00000200", pc_o);
    end
    clear_inputs();
    #1;
    checks++;
    if (flush_o !== 1'b0) begin
      failures++; $display("FAIL flush_idle got %b exp 0", flush_o);
    end
  endtask

  task automatic test_redirect_stall();
    stall_i         = 1'b1;
    branch_taken_i  = 1'b1;
    branch_target_i = 32'h40;
    #1;
    checks++;
    if (flush_o !== 1'b1) begin
      failures++; $display("FAIL rstall_flush got %b exp 1", flush_o);
    end
    step();
    checks++;
    if (pc_o !== 32'h40 || stall_count_o !== 16'd3 || fetch_count_o !== 32'd11) begin
      failures++;
      $display("FAIL rstall_pc got pc=%h sc=%0d fc=%0d exp 40 3 11",
               pc_o, stall_count_o, fetch_count_o);
    end
    clear_inputs();
  endtask

  task automatic test_wrap();
    jump_i        = 1'b1;
    jump_target_i = 32'hFFFF_FFFC;
    step();
    clear_inputs();
    checks++;
    if (pc_o !== 32'hFFFF_FFFC) begin
      failures++; $display("FAIL wrap_load got %h exp fffffffc", pc_o);
    end
    step();
    checks++;
    if (pc_o !== 32'h0 || fetch_count_o !== 32'd13) begin
      failures++; $display("FAIL wrap_pc got pc=%h fc=%0d exp 0 13", pc_o, fetch_count_o);
    end
  endtask

  task automatic test_reset_midop();
    step(); // pc 4
    reset         = 1'b1;
    jump_i        = 1'b1;
    jump_target_i = 32'h500;
    #1;
    checks++;
    if (flush_o !== 1'b0) begin
      failures++; $display("FAIL rst_flush got %b exp 0", flush_o);
    end
    step();
    checks++;
    if (pc_o !== 32'h0 || fetch_count_o !== 32'd0 || stall_count_o !== 16'd0
        || fetch_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_midop got pc=%h fc=%0d sc=%0d fv=%b exp 0 0 0 0",
               pc_o, fetch_count_o, stall_count_o, fetch_valid_o);
    end
    reset = 1'b0;
    clear_inputs();
    step();
    checks++;
    if (fetch_valid_o !== 1'b0) begin
      failures++; $display("FAIL rst_boot got fv=%b exp 0", fetch_valid_o);
    end
    step();
    checks++;
    if (fetch_valid_o !== 1'b1 || pc_o !== 32'h0) begin
      failures++; $display("FAIL rst_rerun got fv=%b pc=%h exp 1 0", fetch_valid_o, pc_o);
    end
  endtask

  task automatic test_misalign();
    branch_taken_i  = 1'b1;
    branch_target_i = 32'h102;
    #1;
    checks++;
    if (flush_o !== 1'b1) begin
      failures++; $display("FAIL mis_flush got %b exp 1", flush_o);
    end
    step();
`ifdef PC_ALIGN_CHECK_EN
    checks++;
    if (pc_o !== 32'h0 || misalign_o !== 1'b1 || fetch_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL mis_trap got pc=%h mis=%b fv=%b exp 0 1 0", pc_o, misalign_o, fetch_valid_o);
    end
    step();
    checks++;
    if (pc_o !== 32'h0 || flush_o !== 1'b0 || fetch_valid_o !== 1'b0
        || fetch_count_o !== 32'd0) begin
      failures++;
      $display("FAIL mis_hold got pc=%h fl=%b fv=%b fc=%0d exp 0 0 0 0",
               pc_o, flush_o, fetch_valid_o, fetch_count_o);
    end
`else
    checks++;
    if (pc_o !== 32'h100 || misalign_o !== 1'b0 || fetch_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL mis_mask got pc=%h mis=%b fv=%b exp 100 0 1", pc_o, misalign_o, fetch_valid_o);
    end
`endif
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_boot_run();
    test_stall();
    test_branch_jump();
    test_redirect_stall();
    test_wrap();
    test_reset_midop();
    test_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
